// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and FP16 constants for the systolic skew feeder.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } feeder_state_t;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_TWO  = 16'h4000;

  // One element travelling down a row's delay line; eot marks the tile's last element.
  typedef struct packed {
    logic [15:0] data;
    logic        enable;
    logic        eot;
  } skew_beat_t;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Valid/ready activation-vector input bus of the skew feeder.
interface systolic_skew_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 4
);
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [ROWS*DATA_WIDTH-1:0] in_data_i;

  modport master (output in_valid_i, output in_data_i, input in_ready_o);
  modport slave  (input in_valid_i, input in_data_i, output in_ready_o);
endinterface

// File: rtl/systolic_skew_feeder_delay_line.sv
// Enable-gated shift register of beats with synchronous flush; one instance per array row.
module systolic_delay_line
  import systolic_pkg::*;
#(
  parameter int  DEPTH = 1,
  parameter type T     = skew_beat_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic adv_i,
  input  T     din_i,
  output T     dout_o
);

  T stage_q [0:DEPTH-1];
  T stage_d [0:DEPTH-1];

  // Flush wins over advance so an abort empties the line even while stalled.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = '0;
      end
    end else if (adv_i) begin
      stage_d[0] = din_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Activation feeder: row r of each accepted vector leaves after r+1 registered stages.
// Optional stall/bubble statistics are built when FEEDER_STAT_EN is defined.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 4,
  parameter int MAX_K      = 256,
  parameter int CNT_W      = $clog2(MAX_K + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      cfg_k_i,
  input  logic                  stall_i,
  systolic_skew_feeder_if.slave in_if,
  output logic [DATA_WIDTH-1:0] activation_out        [0:ROWS-1],
  output logic                  ACTIVATION_ENABLE_out [0:ROWS-1],
  output logic                  END_SIGNAL_out        [0:ROWS-1],
  output logic                  busy_o,
  output logic                  done_o
`ifdef FEEDER_STAT_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           bubble_cycles_o
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  enable;
    logic                  eot;
  } beat_t;

  localparam logic [CNT_W-1:0] K_MAX = CNT_W'(MAX_K);

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_done_q, zero_done_d;
  logic [CNT_W-1:0] k_sat;
  logic             in_ready;
  logic             accept;
  logic             inj_last;
  logic             end_seen;

  beat_t row_in  [0:ROWS-1];
  beat_t row_out [0:ROWS-1];

  assign k_sat    = (cfg_k_i > K_MAX) ? K_MAX : cfg_k_i;
  assign end_seen = (state_q == DRAIN) && row_out[ROWS-1].eot;
  assign in_ready = (state_q == STREAM) && !stall_i && !clear_i;
  assign accept   = in_ready && in_if.in_valid_i;

  assign in_if.in_ready_o = in_ready;
  assign busy_o           = (state_q != IDLE);
  // Gated by stall so a frozen end-of-tile beat still yields exactly one pulse.
  assign done_o           = (zero_done_q || end_seen) && !stall_i && !clear_i;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    zero_done_d = zero_done_q;
    inj_last    = 1'b0;
    if (clear_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      zero_done_d = 1'b0;
    end else if (!stall_i) begin
      zero_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (k_sat == '0) begin
              zero_done_d = 1'b1;
            end else begin
              k_d     = k_sat;
              cnt_d   = '0;
              state_d = STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == k_q - CNT_W'(1)) begin
              inj_last = 1'b1;
              state_d  = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (end_seen) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      zero_done_q <= zero_done_d;
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_in[gi] = accept ?
        beat_t'{data:   in_if.in_data_i[gi*DATA_WIDTH +: DATA_WIDTH],
                enable: 1'b1,
                eot:    inj_last} : '0;

    systolic_delay_line #(
      .DEPTH (gi + 1),
      .T     (beat_t)
    ) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (clear_i),
      .adv_i   (!stall_i),
      .din_i   (row_in[gi]),
      .dout_o  (row_out[gi])
    );

    assign activation_out[gi]        = row_out[gi].data;
    assign ACTIVATION_ENABLE_out[gi] = row_out[gi].enable;
    assign END_SIGNAL_out[gi]        = row_out[gi].eot;
  end

`ifdef FEEDER_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        start_acc;

  assign start_acc = (state_q == IDLE) && start_i && !stall_i && !clear_i;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (start_acc) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (busy_o && stall_i && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if ((state_q == STREAM) && !stall_i && !in_if.in_valid_i && (bubble_cnt_q != '1)) begin
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cycles_o  = stall_cnt_q;
  assign bubble_cycles_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed self-checking bench for systolic_skew_feeder (ROWS=4, MAX_K=8).
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int DW    = 16;
  localparam int ROWS  = 4;
  localparam int MAX_K = 8;
  localparam int CNT_W = $clog2(MAX_K + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear_i;
  logic             start_i;
  logic [CNT_W-1:0] cfg_k_i;
  logic             stall_i;
  logic [DW-1:0]    act      [0:ROWS-1];
  logic             en_arr   [0:ROWS-1];
  logic             end_arr  [0:ROWS-1];
  logic             busy_o;
  logic             done_o;
`ifdef FEEDER_STAT_EN
  logic [31:0]      stall_cycles_o;
  logic [31:0]      bubble_cycles_o;
`endif

  logic [3:0] en_vec;
  logic [3:0] end_vec;

  int n_checks = 0;
  int n_errors = 0;

  // Expected per-cycle vectors, index = cycles after the start edge.
  logic [3:0] t1_en  [0:7] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};
  logic [3:0] t1_end [0:7] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  logic [3:0] t2_en  [0:8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h2, 4'h4, 4'h8, 4'h0};
  logic [3:0] t2_end [0:8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  logic [3:0] t3_en  [0:8] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};

  systolic_skew_feeder_if #(.DATA_WIDTH(DW), .ROWS(ROWS)) in_if ();

  systolic_skew_feeder #(
    .DATA_WIDTH (DW),
    .ROWS       (ROWS),
    .MAX_K      (MAX_K)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .clear_i               (clear_i),
    .start_i               (start_i),
    .cfg_k_i               (cfg_k_i),
    .stall_i               (stall_i),
    .in_if                 (in_if),
    .activation_out        (act),
    .ACTIVATION_ENABLE_out (en_arr),
    .END_SIGNAL_out        (end_arr),
    .busy_o                (busy_o),
    .done_o                (done_o)
`ifdef FEEDER_STAT_EN
    ,
    .stall_cycles_o        (stall_cycles_o),
    .bubble_cycles_o       (bubble_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    en_vec  = '0;
    end_vec = '0;
    for (int i = 0; i < ROWS; i++) begin
      en_vec[i]  = en_arr[i];
      end_vec[i] = end_arr[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ROWS*DW-1:0] splat(input logic [DW-1:0] v);
    return {ROWS{v}};
  endfunction

  // Hand pattern for the basic-skew tile: beats ONE, TWO, ONE; row r lags r+1 cycles.
  function automatic logic [DW-1:0] t1_act(input int c, input int r);
    int b;
    b = c - r - 1;
    if (b == 1) return FP16_TWO;
    if (b == 0 || b == 2) return FP16_ONE;
    return FP16_ZERO;
  endfunction

  task automatic start_tile(input int k);
    start_i = 1'b1;
    cfg_k_i = CNT_W'(k);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_k1(input string tag);
    in_if.in_valid_i = 1'b1;
    in_if.in_data_i  = splat(FP16_ONE);
    start_tile(1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) in_if.in_valid_i = 1'b0;
      check($sformatf("%s end c%0d", tag, c), 32'(end_vec), (c <= 4) ? 32'(1 << (c - 1)) : 32'h0);
      check($sformatf("%s done c%0d", tag, c), 32'(done_o), (c == 4) ? 32'h1 : 32'h0);
    end
    $display("tile %s: k=1 follow-up tile finished", tag);
  endtask

  initial begin
    int beats;
    int ends;
    int dones;

    rst_n            = 1'b0;
    clear_i          = 1'b0;
    start_i          = 1'b0;
    cfg_k_i          = '0;
    stall_i          = 1'b0;
    in_if.in_valid_i = 1'b0;
    in_if.in_data_i  = '0;
    repeat (2) @(negedge clk);
    check("reset en", 32'(en_vec), 32'h0);
    check("reset busy", 32'(busy_o), 32'h0);
    check("reset ready", 32'(in_if.in_ready_o), 32'h0);
    check("reset done", 32'(done_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic skew, k=3.
    in_if.in_valid_i = 1'b1;
    in_if.in_data_i  = splat(FP16_ONE);
    start_tile(3);
    check("t1 ready c0", 32'(in_if.in_ready_o), 32'h1);
    check("t1 busy c0", 32'(busy_o), 32'h1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("t1 en c%0d", c), 32'(en_vec), 32'(t1_en[c]));
      check($sformatf("t1 end c%0d", c), 32'(end_vec), 32'(t1_end[c]));
      check($sformatf("t1 done c%0d", c), 32'(done_o), (c == 6) ? 32'h1 : 32'h0);
      check($sformatf("t1 busy c%0d", c), 32'(busy_o), (c <= 6) ? 32'h1 : 32'h0);
      for (int r = 0; r < ROWS; r++) begin
        check($sformatf("t1 act c%0d r%0d", c, r), 32'(act[r]), 32'(t1_act(c, r)));
      end
      if (c == 1) in_if.in_data_i = splat(FP16_TWO);
      if (c == 2) in_if.in_data_i = splat(FP16_ONE);
      if (c == 3) in_if.in_valid_i = 1'b0;
    end
    $display("tile basic: k=3 skewed over 4 rows");

    // Bubbles, k=2 with a 2-cycle valid gap.
    in_if.in_valid_i = 1'b1;
    in_if.in_data_i  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    start_tile(2);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("t2 en c%0d", c), 32'(en_vec), 32'(t2_en[c]));
      check($sformatf("t2 end c%0d", c), 32'(end_vec), 32'(t2_end[c]));
      check($sformatf("t2 done c%0d", c), 32'(done_o), (c == 7) ? 32'h1 : 32'h0);
      if (c == 2) check("t2 bubble act r0", 32'(act[0]), 32'h0);
      if (c == 4) check("t2 act r0 c4", 32'(act[0]), 32'hB000);
      if (c == 4) check("t2 act r3 c4", 32'(act[3]), 32'hA003);
      if (c == 7) check("t2 act r3 c7", 32'(act[3]), 32'hB003);
      if (c == 1) in_if.in_valid_i = 1'b0;
      if (c == 3) begin
        in_if.in_valid_i = 1'b1;
        in_if.in_data_i  = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
      end
      if (c == 4) in_if.in_valid_i = 1'b0;
    end
    $display("tile bubbles: k=2 with gap");

    // Stall for 3 cycles in DRAIN, k=1.
    in_if.in_valid_i = 1'b1;
    in_if.in_data_i  = splat(FP16_TWO);
    start_tile(1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("t3 en c%0d", c), 32'(en_vec), 32'(t3_en[c]));
      check($sformatf("t3 end c%0d", c), 32'(end_vec), 32'(t3_en[c]));
      check($sformatf("t3 done c%0d", c), 32'(done_o), (c == 7) ? 32'h1 : 32'h0);
      check($sformatf("t3 busy c%0d", c), 32'(busy_o), (c <= 7) ? 32'h1 : 32'h0);
      if (c >= 2 && c <= 4) begin
        check($sformatf("t3 ready c%0d", c), 32'(in_if.in_ready_o), 32'h0);
        check($sformatf("t3 act r0 c%0d", c), 32'(act[0]), 32'(FP16_TWO));
      end
      if (c == 1) begin
        in_if.in_valid_i = 1'b0;
        stall_i          = 1'b1;
      end
      if (c == 4) stall_i = 1'b0;
    end
    $display("tile stall: done delayed by 3 stalled cycles");

    // Abort after 2 of 4 beats, then a normal k=1 tile.
    in_if.in_valid_i = 1'b1;
    in_if.in_data_i  = splat(FP16_ONE);
    start_tile(4);
    @(negedge clk);
    @(negedge clk);
    check("t4 en before clear", 32'(en_vec), 32'h3);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i          = 1'b0;
    in_if.in_valid_i = 1'b0;
    check("t4 en after clear", 32'(en_vec), 32'h0);
    check("t4 busy after clear", 32'(busy_o), 32'h0);
    check("t4 done after clear", 32'(done_o), 32'h0);
    @(negedge clk);
    check("t4 done later", 32'(done_o), 32'h0);
    $display("tile abort: cleared mid-stream");
    run_k1("t4b");

    // k=0: done one cycle after start, no enables.
    start_tile(0);
    check("t5 done", 32'(done_o), 32'h1);
    check("t5 busy", 32'(busy_o), 32'h0);
    check("t5 en", 32'(en_vec), 32'h0);
    @(negedge clk);
    check("t5 done gone", 32'(done_o), 32'h0);
    $display("tile zero: k=0 immediate done");

    // k=MAX_K with an ignored mid-stream start, then cfg_k above MAX_K saturates.
    for (int pass = 0; pass < 2; pass++) begin
      beats = 0;
      ends  = 0;
      dones = 0;
      in_if.in_valid_i = 1'b1;
      in_if.in_data_i  = splat(FP16_ONE);
      start_tile((pass == 0) ? MAX_K : 12);
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (en_vec[0]) beats++;
        if (end_vec[3]) ends++;
        if (done_o) dones++;
        if (c == 3 && pass == 0) begin
          start_i = 1'b1;
          cfg_k_i = CNT_W'(2);
        end
        if (c == 4) start_i = 1'b0;
      end
      in_if.in_valid_i = 1'b0;
      check($sformatf("t6 beats p%0d", pass), 32'(beats), 32'(MAX_K));
      check($sformatf("t6 ends p%0d", pass), 32'(ends), 32'h1);
      check($sformatf("t6 dones p%0d", pass), 32'(dones), 32'h1);
      check($sformatf("t6 idle p%0d", pass), 32'(busy_o), 32'h0);
      $display("tile maxk pass %0d: %0d beats", pass, beats);
    end

    // Asynchronous reset mid-stream.
    in_if.in_valid_i = 1'b1;
    in_if.in_data_i  = splat(FP16_TWO);
    start_tile(4);
    @(negedge clk);
    @(negedge clk);
    check("t7 en before rst", 32'(en_vec), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("t7 en in rst", 32'(en_vec), 32'h0);
    check("t7 act in rst", 32'(act[1]), 32'h0);
    check("t7 busy in rst", 32'(busy_o), 32'h0);
    check("t7 ready in rst", 32'(in_if.in_ready_o), 32'h0);
    @(negedge clk);
    rst_n            = 1'b1;
    in_if.in_valid_i = 1'b0;
    @(negedge clk);
    check("t7 busy after rst", 32'(busy_o), 32'h0);
    check("t7 en after rst", 32'(en_vec), 32'h0);
    $display("tile reset: async reset mid-stream");
    run_k1("t7b");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
